// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int NIBBLE_W = 4;

  // A single-nibble datapath still needs a one-bit counter.
  function automatic int cnt_width(input int nib);
    return (nib <= 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/sub4_cla.sv
// Combinational 4-bit slice: d4 = a4 - b4 - bin with every borrow looked ahead from bin.
module sub4_cla (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       bin,
  output logic [3:0] d4,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] br;

  assign g = ~a4 & b4;
  assign p = ~(a4 ^ b4);

  assign br[0] = bin;
  assign br[1] = g[0] | (p[0] & bin);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
  assign bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d4 = a4 ^ b4 ^ br;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock through a shared
// lookahead-borrow slice, with valid/ready handshakes on both sides.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_next;
  logic            br;
  logic [3:0]      a4;
  logic [3:0]      b4;
  logic [3:0]      d4;
  logic            slice_bout;
  logic            accept;
  logic            last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(NIB - 1));

  sub4_cla u_slice (
    .a4   (a4),
    .b4   (b4),
    .bin  (br),
    .d4   (d4),
    .bout (slice_bout)
  );

  // The counter steers the shared slice onto nibble k and its result back into diff.
  always_comb begin
    a4        = '0;
    b4        = '0;
    diff_next = diff;
    for (int k = 0; k < NIB; k++) begin
      if (cnt == CW'(k)) begin
        a4 = a_r[k*NIBBLE_W +: NIBBLE_W];
        b4 = b_r[k*NIBBLE_W +: NIBBLE_W];
        diff_next[k*NIBBLE_W +: NIBBLE_W] = d4;
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b1;
    end else begin
      state <= state_next;
      if (accept) begin
        a_r <= a;
        b_r <= b;
        br  <= bin;
        cnt <= '0;
      end else if (state == BUSY) begin
        diff <= diff_next;
        br   <= slice_bout;
        cnt  <= cnt + 1'b1;
        // diff_next already holds the final nibble, so zero sees the complete result.
        if (last) begin
          bout <= slice_bout;
          zero <= (diff_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: directed cases with literal results plus randomized traffic
// scored against an arithmetic model of a - b - bin.
module tb_nibble_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
  } exp_t;

  exp_t exp_q[$];

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
    exp_t r;
    int unsigned minuend;
    int unsigned subtrahend;
    minuend    = av;
    subtrahend = bv + bi;
    r.d  = WIDTH'(minuend - subtrahend);
    r.bo = (minuend < subtrahend);
    return r;
  endfunction

  // Every accepted operation becomes one expected result; a completed handshake retires it.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  always @(posedge rst) exp_q.delete();

  // The block is ready exactly when no operation is outstanding.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("in_ready_vs_outstanding", in_ready, exp_q.size() == 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", out_valid, 0);
        end else begin
          checkOutput("model_diff", diff, exp_q[0].d);
          checkOutput("model_bout", bout, exp_q[0].bo);
          checkOutput("model_zero", zero, exp_q[0].d == '0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic bi, input logic noise, output int lat);
    int w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    checkOutput("in_ready_wait", in_ready, 1);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    bin      = 1'($urandom_range(0, 1));
    lat      = 1;
    while (!out_valid && lat < 50) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = 16'hAAAA;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checkOutput("out_valid_timeout", out_valid, 1);
  endtask

  task automatic runDirected(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                             input logic [WIDTH-1:0] ed, input logic eb, input logic ez);
    int lat;
    out_ready = 1'b1;
    applyStimulus(av, bv, bi, 1'b0, lat);
    checkOutput("latency", lat, NIB + 1);
    checkOutput("lit_diff", diff, ed);
    checkOutput("lit_bout", bout, eb);
    checkOutput("lit_zero", zero, ez);
    tick();
    checkOutput("valid_one_cycle", out_valid, 0);
    checkOutput("idle_after_done", in_ready, 1);
  endtask

  initial begin
    int lat;
    int hold;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic [WIDTH-1:0] held_diff;
    logic held_bout;
    logic held_zero;
    logic seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    tick();
    tick();
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_diff", diff, 0);
    checkOutput("reset_bout", bout, 0);
    checkOutput("reset_zero", zero, 1);
    rst = 1'b0;
    tick();

    runDirected(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    runDirected(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    runDirected(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
    runDirected(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    runDirected(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    runDirected(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1);
    runDirected(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1);

    // Backpressure with in_valid pulsed through BUSY and DONE.
    out_ready = 1'b0;
    applyStimulus(16'h00FF, 16'h0100, 1'b0, 1'b1, lat);
    checkOutput("bp_latency", lat, NIB + 1);
    held_diff = diff;
    held_bout = bout;
    held_zero = zero;
    checkOutput("bp_diff", held_diff, 16'hFFFF);
    checkOutput("bp_bout", held_bout, 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = 16'hAAAA;
      b        = 16'h5555;
      tick();
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_ready", in_ready, 0);
      checkOutput("bp_hold_diff", diff, held_diff);
      checkOutput("bp_hold_bout", bout, held_bout);
      checkOutput("bp_hold_zero", zero, held_zero);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);
    runDirected(16'hAAAA, 16'h5555, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Abort two edges after an accept.
    a        = 16'h1234;
    b        = 16'h4321;
    bin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_diff", diff, 0);
    checkOutput("abort_bout", bout, 0);
    checkOutput("abort_zero", zero, 1);
    tick();
    rst        = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    checkOutput("abort_no_valid", seen_valid, 0);
    runDirected(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and in_valid noise.
    for (int i = 0; i < 60; i++) begin
      av = WIDTH'($urandom);
      bv = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) bv = av;
      out_ready = 1'($urandom_range(0, 1));
      applyStimulus(av, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat);
      checkOutput("rand_latency", lat, NIB + 1);
      if (!out_ready) begin
        hold = $urandom_range(0, 4);
        for (int j = 0; j < hold; j++) tick();
        out_ready = 1'b1;
      end
      tick();
      hold = $urandom_range(0, 2);
      for (int j = 0; j < hold; j++) tick();
    end

    tick();
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
